// File: rtl/divider.sv
// rtl/divider.sv - iterative radix-2 restoring divider for MIPS DIV/DIVU
// One quotient bit per cycle on operand magnitudes; signs are applied when results are registered.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             q_neg_q, r_neg_q, dz_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;

    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] rem_d, quo_d, q_fix, r_fix;
    logic             last_iter;

    always_comb begin
        dvd_mag = (signed_i && dividend_i[WIDTH-1]) ? (~dividend_i + 1'b1) : dividend_i;
        dvs_mag = (signed_i && divisor_i[WIDTH-1])  ? (~divisor_i + 1'b1)  : divisor_i;

        // rem_sh carries one extra bit because rem can be as large as divisor-1
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        rem_d  = rem_sh[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_d    = trial[WIDTH-1:0];
            quo_d[0] = 1'b1;
        end

        // A zero divisor leaves rem = |dividend|, so re-signing yields the raw dividend
        q_fix = dz_q ? {WIDTH{1'b1}} : (q_neg_q ? (~quo_d + 1'b1) : quo_d);
        r_fix = r_neg_q ? (~rem_d + 1'b1) : rem_d;

        last_iter = (count_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i && !flush_i) begin
                        rem_q   <= '0;
                        quo_q   <= dvd_mag;
                        dvs_q   <= dvs_mag;
                        q_neg_q <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        r_neg_q <= signed_i && dividend_i[WIDTH-1];
                        dz_q    <= (divisor_i == '0);
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q   <= rem_d;
                        quo_q   <= quo_d;
                        count_q <= count_q + 1'b1;
                        if (last_iter) begin
                            quotient_q  <= q_fix;
                            remainder_q <= r_fix;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for divider
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_divider;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    int tests = 0;
    int fails = 0;

    divider #(.WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .flush_i     (flush_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then track busy/done up to a bounded number of cycles.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] exp_q, input logic [31:0] exp_r);
        int cyc;
        int busy_cnt;
        logic [31:0] prev_q;
        logic [31:0] prev_r;
        prev_q     = quotient_o;
        prev_r     = remainder_o;
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        check({tag, "_hold_q"}, quotient_o, prev_q);
        check({tag, "_hold_r"}, remainder_o, prev_r);
        while (!done_o && cyc <= 40) begin
            if (busy_o) busy_cnt++;
            @(negedge clk_i);
            cyc++;
        end
        check({tag, "_done_cycle"}, cyc, 33);
        check({tag, "_busy_cycles"}, busy_cnt, 32);
        check({tag, "_busy_at_done"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_quo"}, quotient_o, exp_q);
        check({tag, "_rem"}, remainder_o, exp_r);
        @(negedge clk_i);
        check({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
        check({tag, "_quo_held"}, quotient_o, exp_q);
    endtask

    initial begin
        int done_seen;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_quo", quotient_o, 32'd0);
        check("rst_rem", remainder_o, 32'd0);

        run_div("u100_7",    32'd100,        32'd7,          1'b0, 32'd14,       32'd2);
        run_div("s-7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("s7_-2",     32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1);
        run_div("u7_big",    32'd7,          32'hFFFF_FFFE,  1'b0, 32'd0,        32'd7);
        run_div("s_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0);
        run_div("u_max_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0);
        run_div("u_dz",      32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div("s_dz",      32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div("s_dz_neg",  32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run_div("s-100_-7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,       32'hFFFF_FFFE);

        // Start during CALC is ignored; operands are not re-sampled.
        dividend_i = 32'd100; divisor_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (8) @(negedge clk_i);
        dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40 && done_seen == 0; i++) begin
            if (done_o) done_seen = 1;
            else @(negedge clk_i);
        end
        check("mid_start_done", done_seen, 1);
        check("mid_start_quo", quotient_o, 32'd14);
        check("mid_start_rem", remainder_o, 32'd2);

        // Start during DONE is ignored.
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("done_start_busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);

        // Flush mid-division: no done pulse, outputs retained.
        dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (13) @(negedge clk_i);
        check("pre_flush_busy", {31'b0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_busy", {31'b0, busy_o}, 32'd0);
        check("flush_done", {31'b0, done_o}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) done_seen = 1;
            @(negedge clk_i);
        end
        check("flush_no_done", done_seen, 0);
        check("flush_quo", quotient_o, 32'd14);
        check("flush_rem", remainder_o, 32'd2);

        // Flush with start in IDLE drops the start.
        start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        check("idle_flush_start", {31'b0, busy_o}, 32'd0);

        // Reset mid-division clears everything.
        dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (18) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_quo", quotient_o, 32'd0);
        check("midrst_rem", remainder_o, 32'd0);

        run_div("after_rst", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
